// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling, sticky ready/overrun/frame-error flags
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       rx_clear,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       rx_busy,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_END = 16'(HALF_BIT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        ready_q, ready_d;
   logic        ovr_q, ovr_d;
   logic        ferr_q, ferr_d;
   logic        s1_q, s1_d;
   logic        s2_q, s2_d;

   assign rx_data      = data_q;
   assign rx_ready     = ready_q;
   assign rx_overrun   = ovr_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = (state_q != IDLE);

   // next-state: framing FSM, baud counter, shifter and sticky flags
   always_comb begin
      s1_d    = rxd;
      s2_d    = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = ready_q & ~rx_clear;
      ovr_d   = ovr_q & ~rx_clear;
      ferr_d  = ferr_q & ~rx_clear;
      case (state_q)
         IDLE: begin
            cnt_d   = 16'd0;
            state_d = s2_q ? IDLE : START;
         end
         START: begin
            if (cnt_q == HALF_END) begin
               cnt_d   = 16'd0;
               bit_d   = 3'd0;
               state_d = s2_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = 16'd0;
               shift_d = {s2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
         end
         STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = 16'd0;
               if (s2_q) begin
                  // a delivery beats a coincident clear; overrun only if the old byte was never consumed
                  data_d  = shift_q;
                  ready_d = 1'b1;
                  ovr_d   = ovr_d | (ready_q & ~rx_clear);
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BRK;
               end
            end
         end
         default: begin
            // held-low line: wait for it to return high before hunting for a new start bit
            cnt_d   = 16'd0;
            state_d = s2_q ? IDLE : BRK;
         end
      endcase
   end

   // state registers with synchronous reset; synchroniser resets to the idle level
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         ready_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with directed and random 8N1 frames
module tb_uart_rx;

   localparam int CPB   = 16;
   localparam int HALF  = CPB / 2;
   localparam int FRAME = 10 * CPB;
   localparam int LAT   = 2 + HALF + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       rx_clear = 1'b0;
   logic [7:0] rx_data;
   logic       rx_ready, rx_busy, rx_overrun, rx_frame_err;

   typedef struct {
      logic [7:0] b;
      int         t;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   logic prev_ready = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .rxd(rxd),
      .rx_clear(rx_clear),
      .rx_data(rx_data),
      .rx_ready(rx_ready),
      .rx_busy(rx_busy),
      .rx_overrun(rx_overrun),
      .rx_frame_err(rx_frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // monitor: every rising rx_ready must match the oldest expected byte and its latency
   initial begin
      forever begin
         @(negedge clk);
         if (rx_ready && !prev_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_byte: got %02h, expected no delivery", rx_data);
            end else begin
               exp_t e;
               int   lat;
               e   = exp_q.pop_front();
               lat = cyc - e.t;
               if (rx_data !== e.b) begin
                  fails++;
                  $display("FAIL byte_data: got %02h expected %02h", rx_data, e.b);
               end
               tests++;
               if (lat < LAT - 2 || lat > LAT + 2) begin
                  fails++;
                  $display("FAIL latency: got %0d clocks expected %0d +/-2", lat, LAT);
               end
            end
         end
         prev_ready = rx_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drive one frame; clear_at>0 pulses rx_clear at that clock offset; extra_low extends a low line
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit rise,
                             input int clear_at, input int extra_low);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      if (rise) exp_q.push_back('{b, cyc});
      for (int c = 0; c < FRAME; c++) begin
         rxd      = bits[c / CPB];
         rx_clear = (clear_at > 0 && c == clear_at);
         tick();
      end
      rx_clear = 1'b0;
      for (int c = 0; c < extra_low; c++) begin
         rxd = 1'b0;
         tick();
      end
      rxd = 1'b1;
   endtask

   task automatic pulse_clear();
      rx_clear = 1'b1;
      tick();
      rx_clear = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   initial begin
      int busy_cnt;
      logic [9:0] pbits;
      // reset state
      tick();
      tick();
      check("reset_outputs", {rx_data, rx_ready, rx_busy, rx_overrun, rx_frame_err}, 32'h0);
      rst = 1'b0;
      idle(5);
      // 1: single byte, then clear
      send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
      check("t1_data", rx_data, 8'hA5);
      check("t1_ferr", rx_frame_err, 1'b0);
      pulse_clear();
      check("t1_ready_cleared", rx_ready, 1'b0);
      check("t1_data_held", rx_data, 8'hA5);
      // 2: back-to-back frames, first byte cleared during the second frame
      idle(3);
      send_frame(8'h3C, 1'b1, 1'b1, 0, 0);
      send_frame(8'hC3, 1'b1, 1'b1, 10, 0);
      check("t2_data", rx_data, 8'hC3);
      check("t2_flags", {rx_overrun, rx_frame_err}, 2'b00);
      pulse_clear();
      // 3: overrun
      idle(4);
      send_frame(8'h11, 1'b1, 1'b1, 0, 0);
      send_frame(8'h22, 1'b1, 1'b0, 0, 0);
      check("t3_data", rx_data, 8'h22);
      check("t3_ready", rx_ready, 1'b1);
      check("t3_overrun", rx_overrun, 1'b1);
      pulse_clear();
      check("t3_cleared", {rx_ready, rx_overrun}, 2'b00);
      // 4: short glitch rejected
      busy_cnt = 0;
      for (int c = 0; c < 24; c++) begin
         rxd = (c < 4) ? 1'b0 : 1'b1;
         tick();
         busy_cnt += int'(rx_busy);
      end
      tests++;
      if (busy_cnt < 1 || busy_cnt > 8) begin
         fails++;
         $display("FAIL t4_busy_len: got %0d clocks expected 1..8", busy_cnt);
      end
      check("t4_ready", rx_ready, 1'b0);
      check("t4_busy_idle", rx_busy, 1'b0);
      // 5: bad stop bit followed by a long low line, then a good byte
      send_frame(8'h55, 1'b0, 1'b0, 0, 100);
      check("t5_ferr", rx_frame_err, 1'b1);
      check("t5_no_ready", rx_ready, 1'b0);
      idle(6);
      check("t5_back_idle", rx_busy, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b1, 0, 0);
      check("t5_data", rx_data, 8'h0F);
      check("t5_ferr_sticky", rx_frame_err, 1'b1);
      pulse_clear();
      check("t5_cleared", {rx_ready, rx_frame_err}, 2'b00);
      // 6: reset in the middle of data bit 4
      idle(3);
      pbits = {1'b1, 8'h96, 1'b0};
      for (int c = 0; c < 5 * CPB + HALF; c++) begin
         rxd = pbits[c / CPB];
         tick();
      end
      rst = 1'b1;
      rxd = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_reset_outputs", {rx_data, rx_ready, rx_busy, rx_overrun, rx_frame_err}, 32'h0);
      idle(20);
      check("t6_no_byte", rx_ready, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b1, 0, 0);
      check("t6_data", rx_data, 8'hFF);
      check("t6_ferr", rx_frame_err, 1'b0);
      pulse_clear();
      // random frames with random gaps, each frame clearing the previous byte mid-frame
      for (int i = 0; i < 24; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         idle($urandom_range(0, 20));
         send_frame(b, 1'b1, 1'b1, 1 + $urandom_range(0, 100), 0);
         check("rnd_data", rx_data, b);
      end
      check("rnd_flags", {rx_overrun, rx_frame_err}, 2'b00);
      pulse_clear();
      idle(10);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
